// File: rtl/f7_frame_accum_pkg.sv
// Shared definitions for the 7-bit float frame accumulator: field widths,
// FSM state type and the float-to-integer decode used by stage 1.
package f7_pkg;

  localparam int F7_EXP_W = 3;
  localparam int F7_MAN_W = 4;
  localparam int F7_INT_W = 11;
  localparam int F7_W     = F7_EXP_W + F7_MAN_W;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_e;

  // Exponent 0 is a denormal (plain mantissa); otherwise the hidden one is restored.
  function automatic logic [F7_INT_W-1:0] f7_decode(input logic [F7_W-1:0] f);
    logic [F7_EXP_W-1:0] e;
    logic [F7_MAN_W-1:0] m;
    logic [F7_INT_W-1:0] mant_ext;
    e = f[F7_W-1:F7_MAN_W];
    m = f[F7_MAN_W-1:0];
    mant_ext = {{(F7_INT_W-F7_MAN_W-1){1'b0}}, 1'b1, m};
    if (e == '0) begin
      f7_decode = {{(F7_INT_W-F7_MAN_W){1'b0}}, m};
    end else begin
      f7_decode = mant_ext << (e - 3'd1);
    end
  endfunction

endpackage

// File: rtl/f7_frame_accum_if.sv
// Sample input stream and per-frame record output of the frame accumulator.
// The slave modport is the accumulator side, master is the producer/consumer side.
interface f7_frame_accum_if #(
  parameter int SUM_W = 18,
  parameter int CNT_W = 9
);
  import f7_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [F7_W-1:0]   in_float;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [CNT_W-1:0]  out_count;
  logic              out_sat;
  logic              out_trunc;

  modport slave (
    input  in_valid, in_float, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
  );

  modport master (
    output in_valid, in_float, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_sat, out_trunc
  );

endinterface

// File: rtl/f7_frame_accum_decode_reg.sv
// Stage 1: decodes an accepted float to its 11-bit magnitude and registers it
// together with the frame-closing tags.
module f7_decode_reg
  import f7_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                accept,
  input  logic [F7_W-1:0]     in_float,
  input  logic                in_last,
  input  logic                trunc_tag,
  output logic                s1_valid_q,
  output logic [F7_INT_W-1:0] s1_value_q,
  output logic                s1_last_q,
  output logic                s1_trunc_q
);

  logic                s1_valid_d;
  logic [F7_INT_W-1:0] s1_value_d;
  logic                s1_last_d;
  logic                s1_trunc_d;

  always_comb begin
    s1_valid_d = accept;
    s1_value_d = s1_value_q;
    s1_last_d  = s1_last_q;
    s1_trunc_d = s1_trunc_q;
    if (accept) begin
      s1_value_d = f7_decode(in_float);
      s1_last_d  = in_last;
      s1_trunc_d = trunc_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_value_q <= '0;
      s1_last_q  <= 1'b0;
      s1_trunc_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_value_q <= s1_value_d;
      s1_last_q  <= s1_last_d;
      s1_trunc_q <= s1_trunc_d;
    end
  end

endmodule

// File: rtl/f7_frame_accum.sv
// Frame accumulator: sums decoded 7-bit floats over a frame (closed by in_last
// or MAX_FRAME samples) and emits one saturated {sum, count, flags} record.
module f7_frame_accum
  import f7_pkg::*;
#(
  parameter int SUM_W     = 18,
  parameter int MAX_FRAME = 256,
  parameter int CNT_W     = 9
) (
  input logic             clk,
  input logic             rst_n,
  f7_frame_accum_if.slave bus
);

  localparam int SUM_W1 = SUM_W + 1;

  state_e              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [SUM_W-1:0]    sum_q, sum_d;
  logic                sat_q, sat_d;
  logic [SUM_W-1:0]    out_sum_q, out_sum_d;
  logic [CNT_W-1:0]    out_count_q, out_count_d;
  logic                out_sat_q, out_sat_d;
  logic                out_trunc_q, out_trunc_d;

  logic                accept;
  logic [CNT_W-1:0]    cnt_inc;
  logic                hit_max;
  logic                close_frame;
  logic                trunc_tag;

  logic                s1_valid;
  logic [F7_INT_W-1:0] s1_value;
  logic                s1_last;
  logic                s1_trunc;
  logic                frame_end;

  logic [SUM_W:0]      sum_wide;
  logic                add_ovf;
  logic [SUM_W-1:0]    sum_add;

  // The count is kept at accept time so the MAX_FRAME close can be tagged in stage 1.
  assign accept      = bus.in_valid & in_ready_q;
  assign cnt_inc     = cnt_q + 1'b1;
  assign hit_max     = (cnt_inc == CNT_W'(MAX_FRAME));
  assign close_frame = accept & (bus.in_last | hit_max);
  assign trunc_tag   = hit_max & ~bus.in_last;

  f7_decode_reg u_decode_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept     (accept),
    .in_float   (bus.in_float),
    .in_last    (bus.in_last),
    .trunc_tag  (trunc_tag),
    .s1_valid_q (s1_valid),
    .s1_value_q (s1_value),
    .s1_last_q  (s1_last),
    .s1_trunc_q (s1_trunc)
  );

  assign frame_end = s1_valid & (s1_last | s1_trunc);

  // Saturating add; once pinned at all-ones any further carry keeps it there.
  assign sum_wide = {1'b0, sum_q} + SUM_W1'(s1_value);
  assign add_ovf  = s1_valid & sum_wide[SUM_W];
  assign sum_add  = !s1_valid ? sum_q :
                    add_ovf   ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sat_d       = sat_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    out_trunc_d = out_trunc_q;
    if (accept) begin
      cnt_d = cnt_inc;
    end
    unique case (state_q)
      ACCUM: begin
        sum_d = sum_add;
        sat_d = sat_q | add_ovf;
        if (close_frame) begin
          state_d    = DRAIN;
          in_ready_d = 1'b0;
        end
      end
      DRAIN: begin
        if (frame_end) begin
          out_sum_d   = sum_add;
          out_count_d = cnt_q;
          out_sat_d   = sat_q | add_ovf;
          out_trunc_d = s1_trunc;
          out_valid_d = 1'b1;
          sum_d       = '0;
          sat_d       = 1'b0;
          cnt_d       = '0;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          out_sum_d   = '0;
          out_count_d = '0;
          out_sat_d   = 1'b0;
          out_trunc_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ACCUM;
        end
      end
      default: begin
        state_d    = ACCUM;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      sat_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      sat_q       <= sat_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_count = out_count_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_trunc = out_trunc_q;

endmodule

// File: tb/tb_f7_frame_accum.sv
// Bench for f7_frame_accum: directed frames on three parameterisations plus a
// randomized run on the MAX_FRAME=4 instance against an integer frame model.
module tb_f7_frame_accum;

  localparam int T_MAX   = 4;
  localparam int T_SUMW  = 18;
  localparam int T_SATMX = (1 << T_SUMW) - 1;

  typedef struct {
    int sum;
    int cnt;
    bit sat;
    bit trunc;
  } rec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  int   n_fail;

  rec_t exp_q[$];
  int   m_sum;
  int   m_cnt;

  f7_frame_accum_if #(.SUM_W(18), .CNT_W(9)) bus_a ();
  f7_frame_accum_if #(.SUM_W(12), .CNT_W(9)) bus_s ();
  f7_frame_accum_if #(.SUM_W(18), .CNT_W(3)) bus_t ();

  f7_frame_accum #(.SUM_W(18), .MAX_FRAME(256), .CNT_W(9)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  f7_frame_accum #(.SUM_W(12), .MAX_FRAME(256), .CNT_W(9)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s)
  );
  f7_frame_accum #(.SUM_W(18), .MAX_FRAME(T_MAX), .CNT_W(3)) dut_t (
    .clk(clk), .rst_n(rst_n), .bus(bus_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [6:0] f, input logic last);
    checkOutput("a_in_ready_before_send", bus_a.in_ready, 1);
    bus_a.in_valid = 1'b1;
    bus_a.in_float = f;
    bus_a.in_last  = last;
    tick();
    bus_a.in_valid = 1'b0;
    bus_a.in_last  = 1'b0;
  endtask

  // Reference decode straight from the float definition.
  function automatic int decodeRef(input int f);
    int e;
    int m;
    e = (f >> 4) & 7;
    m = f & 15;
    return (e == 0) ? m : (16 + m) * (1 << (e - 1));
  endfunction

  task automatic modelAccept(input int f, input bit last);
    rec_t r;
    m_sum += decodeRef(f);
    m_cnt++;
    if (last || m_cnt == T_MAX) begin
      r.sum   = (m_sum > T_SATMX) ? T_SATMX : m_sum;
      r.cnt   = m_cnt;
      r.sat   = (m_sum > T_SATMX);
      r.trunc = !last;
      exp_q.push_back(r);
      m_sum = 0;
      m_cnt = 0;
    end
  endtask

  initial begin
    int          accepted;
    bit          held;
    logic [31:0] h_sum;
    logic [31:0] h_cnt;
    logic [1:0]  h_flags;
    rec_t        got;

    n_checks = 0;
    n_pass   = 0;
    n_fail   = 0;
    m_sum    = 0;
    m_cnt    = 0;
    rst_n    = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_float = '0; bus_a.in_last = 1'b0; bus_a.out_ready = 1'b1;
    bus_s.in_valid = 1'b0; bus_s.in_float = '0; bus_s.in_last = 1'b0; bus_s.out_ready = 1'b1;
    bus_t.in_valid = 1'b0; bus_t.in_float = '0; bus_t.in_last = 1'b0; bus_t.out_ready = 1'b0;

    // Reset and idle
    repeat (3) tick();
    checkOutput("rst_out_valid", bus_a.out_valid, 0);
    rst_n = 1'b1;
    repeat (5) tick();
    checkOutput("idle_out_valid", bus_a.out_valid, 0);
    checkOutput("idle_in_ready", bus_a.in_ready, 1);
    checkOutput("idle_out_sum", bus_a.out_sum, 0);
    checkOutput("idle_out_count", bus_a.out_count, 0);
    checkOutput("idle_flags", {bus_a.out_sat, bus_a.out_trunc}, 0);

    // Frame {0x15, 0x7F, 0x03 last}
    $display("[TB] basic frame");
    applyStimulus(7'h15, 1'b0);
    applyStimulus(7'h7F, 1'b0);
    applyStimulus(7'h03, 1'b1);
    checkOutput("basic_valid_t1", bus_a.out_valid, 0);
    checkOutput("basic_in_ready_t1", bus_a.in_ready, 0);
    tick();
    checkOutput("basic_valid_t2", bus_a.out_valid, 1);
    checkOutput("basic_sum", bus_a.out_sum, 2008);
    checkOutput("basic_count", bus_a.out_count, 3);
    checkOutput("basic_flags", {bus_a.out_sat, bus_a.out_trunc}, 0);
    checkOutput("basic_in_ready_hold", bus_a.in_ready, 0);
    tick();
    checkOutput("basic_valid_after_take", bus_a.out_valid, 0);
    checkOutput("basic_in_ready_after_take", bus_a.in_ready, 1);
    checkOutput("basic_sum_cleared", bus_a.out_sum, 0);

    // Backpressure: record held for 10 cycles, junk input ignored meanwhile
    $display("[TB] backpressure");
    bus_a.out_ready = 1'b0;
    applyStimulus(7'h20, 1'b0);
    applyStimulus(7'h01, 1'b1);
    for (int c = 0; c < 5 && !bus_a.out_valid; c++) tick();
    checkOutput("bp_valid_seen", bus_a.out_valid, 1);
    bus_a.in_valid = 1'b1;
    bus_a.in_float = 7'h7F;
    bus_a.in_last  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      checkOutput("bp_hold_valid", bus_a.out_valid, 1);
      checkOutput("bp_hold_sum", bus_a.out_sum, 33);
      checkOutput("bp_hold_count", bus_a.out_count, 2);
      checkOutput("bp_hold_in_ready", bus_a.in_ready, 0);
      tick();
    end
    bus_a.out_ready = 1'b1;
    tick();
    bus_a.in_valid  = 1'b0;
    bus_a.in_last   = 1'b0;
    bus_a.out_ready = 1'b0;
    checkOutput("bp_in_ready_after_pulse", bus_a.in_ready, 1);
    checkOutput("bp_valid_after_pulse", bus_a.out_valid, 0);
    bus_a.out_ready = 1'b1;

    // Saturation on the 12-bit instance
    $display("[TB] saturation");
    for (int i = 0; i < 3; i++) begin
      bus_s.in_valid = 1'b1;
      bus_s.in_float = 7'h7F;
      bus_s.in_last  = (i == 2);
      tick();
    end
    bus_s.in_valid = 1'b0;
    bus_s.in_last  = 1'b0;
    for (int c = 0; c < 5 && !bus_s.out_valid; c++) tick();
    checkOutput("sat_valid", bus_s.out_valid, 1);
    checkOutput("sat_sum", bus_s.out_sum, 4095);
    checkOutput("sat_flag", bus_s.out_sat, 1);
    checkOutput("sat_count", bus_s.out_count, 3);
    checkOutput("sat_trunc", bus_s.out_trunc, 0);
    tick();
    checkOutput("sat_flag_cleared", bus_s.out_sat, 0);

    // MAX_FRAME=4 truncation with six 0x11 samples
    $display("[TB] truncation");
    accepted = 0;
    bus_t.in_valid = 1'b1;
    bus_t.in_float = 7'h11;
    bus_t.in_last  = 1'b0;
    for (int c = 0; c < 20 && !bus_t.out_valid; c++) begin
      if (bus_t.in_ready) accepted++;
      tick();
    end
    checkOutput("trunc_valid", bus_t.out_valid, 1);
    checkOutput("trunc_accepted", accepted, 4);
    checkOutput("trunc_sum", bus_t.out_sum, 68);
    checkOutput("trunc_count", bus_t.out_count, 4);
    checkOutput("trunc_flag", bus_t.out_trunc, 1);
    checkOutput("trunc_sat", bus_t.out_sat, 0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("trunc_in_ready_hold", bus_t.in_ready, 0);
      checkOutput("trunc_sum_hold", bus_t.out_sum, 68);
      tick();
    end
    bus_t.out_ready = 1'b1;
    tick();
    bus_t.out_ready = 1'b0;
    checkOutput("trunc_in_ready_after", bus_t.in_ready, 1);
    for (int c = 0; c < 10 && accepted < 6; c++) begin
      if (bus_t.in_ready) accepted++;
      tick();
    end
    bus_t.in_valid = 1'b0;
    repeat (4) tick();
    checkOutput("trunc_partial_accepted", accepted, 6);
    checkOutput("trunc_partial_no_valid", bus_t.out_valid, 0);

    // Reset mid-frame, then a single-sample frame
    $display("[TB] reset mid-frame");
    applyStimulus(7'h7F, 1'b0);
    applyStimulus(7'h7F, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", bus_a.in_ready, 1);
    checkOutput("mid_rst_valid", bus_a.out_valid, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    applyStimulus(7'h08, 1'b1);
    for (int c = 0; c < 5 && !bus_a.out_valid; c++) tick();
    checkOutput("post_rst_valid", bus_a.out_valid, 1);
    checkOutput("post_rst_sum", bus_a.out_sum, 8);
    checkOutput("post_rst_count", bus_a.out_count, 1);
    checkOutput("post_rst_flags", {bus_a.out_sat, bus_a.out_trunc}, 0);
    tick();

    // Randomized traffic on the MAX_FRAME=4 instance
    $display("[TB] random traffic");
    held = 1'b0;
    h_sum = '0;
    h_cnt = '0;
    h_flags = '0;
    for (int c = 0; c < 600; c++) begin
      if (held) begin
        checkOutput("r_hold_valid", bus_t.out_valid, 1);
        checkOutput("r_hold_sum", bus_t.out_sum, h_sum);
        checkOutput("r_hold_count", bus_t.out_count, h_cnt);
        checkOutput("r_hold_flags", {bus_t.out_sat, bus_t.out_trunc}, h_flags);
      end
      if (bus_t.out_valid) checkOutput("r_in_ready_in_hold", bus_t.in_ready, 0);
      bus_t.out_ready = ($urandom_range(0, 2) != 0);
      held = 1'b0;
      if (bus_t.out_valid) begin
        if (bus_t.out_ready) begin
          checkOutput("r_exp_avail", (exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            got = exp_q.pop_front();
            checkOutput("r_sum", bus_t.out_sum, got.sum);
            checkOutput("r_count", bus_t.out_count, got.cnt);
            checkOutput("r_sat", bus_t.out_sat, got.sat);
            checkOutput("r_trunc", bus_t.out_trunc, got.trunc);
          end
        end else begin
          held    = 1'b1;
          h_sum   = bus_t.out_sum;
          h_cnt   = bus_t.out_count;
          h_flags = {bus_t.out_sat, bus_t.out_trunc};
        end
      end
      bus_t.in_valid = ($urandom_range(0, 3) != 0);
      bus_t.in_float = 7'($urandom_range(0, 127));
      bus_t.in_last  = ($urandom_range(0, 4) == 0);
      if (bus_t.in_valid && bus_t.in_ready) modelAccept(int'(bus_t.in_float), bus_t.in_last);
      tick();
    end
    bus_t.in_valid  = 1'b0;
    bus_t.out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus_t.out_valid) begin
        checkOutput("r_drain_avail", (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          got = exp_q.pop_front();
          checkOutput("r_drain_sum", bus_t.out_sum, got.sum);
          checkOutput("r_drain_count", bus_t.out_count, got.cnt);
          checkOutput("r_drain_flags", {bus_t.out_sat, bus_t.out_trunc}, {got.sat, got.trunc});
        end
      end
      tick();
    end
    checkOutput("r_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
